// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the forwarding / hazard unit.
package fwd_pkg;

    // Forward select value meaning "take the operand from the register file".
    localparam int FWD_SEL_RF = 0;

    // Forwarding stage k (0 = youngest) is encoded as select value k+1.
    function automatic int stage_to_sel(input int stage);
        return stage + 1;
    endfunction

    // Producers claiming more latency than the scoreboard can track are
    // held for the maximum instead.
    function automatic int clamp_lat(input int lat, input int max_lat);
        return (lat > max_lat) ? max_lat : lat;
    endfunction

endpackage

// File: rtl/fwd_scoreboard.sv
// Per-register latency scoreboard. Each register has a down-counter that is
// loaded with the remaining latency of an in-flight multi-cycle producer;
// a register is busy while its counter is nonzero.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MAX_LAT = 7,
    parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 load_en,
    input  logic [REG_AW-1:0]    load_dest,
    input  logic [LAT_W-1:0]     load_lat,
    output logic [2**REG_AW-1:0] busy
);

    localparam int NUM_REGS = 2**REG_AW;

    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic [LAT_W-1:0] load_val;

    // Clamp the requested latency to what a counter may hold.
    always_comb begin
        load_val = LAT_W'(clamp_lat(int'(load_lat), MAX_LAT));
    end

    // Counter update: flush clears all, a load overrides the decrement of
    // its own entry, every other nonzero entry counts down by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (load_en && (load_dest == REG_AW'(r))) begin
                    cnt[r] <= load_val;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    // A register is busy while its counter has not yet drained.
    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, issue stall and stall-cycle counter for the
// multicycle MIPS datapath. Sits beside ID/EX.
//
// Handshake: issue_valid is the request from ID; stall is the back-pressure.
// An instruction enters EX in exactly the cycle issue_fire = issue_valid &
// ~stall; ID must hold the instruction steady while stall is high.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int NUM_STAGES = 2,
    parameter int REG_AW     = 5,
    parameter int MAX_LAT    = 7,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1),
    parameter int CNT_W      = 16,
    parameter int LAT_W      = $clog2(MAX_LAT + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC*REG_AW-1:0]    src_addr,
    input  logic [NUM_SRC-1:0]           src_used,
    input  logic [NUM_STAGES*REG_AW-1:0] stage_dest,
    input  logic [NUM_STAGES-1:0]        stage_wb_en,
    input  logic                         forwarding_enable,
    input  logic                         issue_valid,
    input  logic [REG_AW-1:0]            issue_dest,
    input  logic                         issue_wb_en,
    input  logic [LAT_W-1:0]             issue_lat,
    input  logic                         flush,
    output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
    output logic                         stall,
    output logic                         issue_fire,
    output logic [CNT_W-1:0]             stall_cnt
);

    logic [NUM_SRC-1:0][NUM_STAGES-1:0] match;
    logic [2**REG_AW-1:0]               busy;
    logic                               raw_busy;
    logic                               waw_busy;
    logic                               interlock;
    logic                               sb_load;

    // Operand/stage address match; register 0 never matches.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                match[i][k] = src_used[i] && stage_wb_en[k] &&
                              (stage_dest[k*REG_AW +: REG_AW] == src_addr[i*REG_AW +: REG_AW]) &&
                              (src_addr[i*REG_AW +: REG_AW] != '0);
            end
        end
    end

    // Forward select per operand; walking oldest to youngest lets the
    // youngest matching stage overwrite and win.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(FWD_SEL_RF);
            if (forwarding_enable) begin
                for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                    if (match[i][k]) begin
                        fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(stage_to_sel(k));
                    end
                end
            end
        end
    end

    // Hazard sources: read of a busy register, write behind a pending
    // write, or any match when forwarding is switched off.
    always_comb begin
        raw_busy = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_used[i] && (src_addr[i*REG_AW +: REG_AW] != '0) &&
                busy[src_addr[i*REG_AW +: REG_AW]]) begin
                raw_busy = 1'b1;
            end
        end
        waw_busy   = issue_wb_en && (issue_dest != '0) && busy[issue_dest];
        interlock  = !forwarding_enable && (|match);
        stall      = issue_valid && (raw_busy || waw_busy || interlock);
        issue_fire = issue_valid && !stall;
        sb_load    = issue_fire && issue_wb_en && (issue_lat != '0) && (issue_dest != '0);
    end

    fwd_scoreboard #(
        .REG_AW  (REG_AW),
        .MAX_LAT (MAX_LAT),
        .LAT_W   (LAT_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .load_en   (sb_load),
        .load_dest (issue_dest),
        .load_lat  (issue_lat),
        .busy      (busy)
    );

    // Saturating count of stalled cycles; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding priority, register 0 and
// unused operands, load-use and WAW stalls, flush, interlock mode, stall
// counter saturation and asynchronous reset.
module tb_fwd_hazard_unit;

    localparam int NUM_SRC    = 3;
    localparam int NUM_STAGES = 2;
    localparam int REG_AW     = 5;
    localparam int MAX_LAT    = 7;
    localparam int SEL_W      = 2;
    localparam int CNT_W      = 4;
    localparam int LAT_W      = 3;

    logic                         clk;
    logic                         rst_n;
    logic [NUM_SRC*REG_AW-1:0]    src_addr;
    logic [NUM_SRC-1:0]           src_used;
    logic [NUM_STAGES*REG_AW-1:0] stage_dest;
    logic [NUM_STAGES-1:0]        stage_wb_en;
    logic                         forwarding_enable;
    logic                         issue_valid;
    logic [REG_AW-1:0]            issue_dest;
    logic                         issue_wb_en;
    logic [LAT_W-1:0]             issue_lat;
    logic                         flush;
    logic [NUM_SRC*SEL_W-1:0]     fwd_sel;
    logic                         stall;
    logic                         issue_fire;
    logic [CNT_W-1:0]             stall_cnt;

    int total;
    int bad;

    fwd_hazard_unit #(
        .NUM_SRC    (NUM_SRC),
        .NUM_STAGES (NUM_STAGES),
        .REG_AW     (REG_AW),
        .MAX_LAT    (MAX_LAT),
        .SEL_W      (SEL_W),
        .CNT_W      (CNT_W),
        .LAT_W      (LAT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .src_addr          (src_addr),
        .src_used          (src_used),
        .stage_dest        (stage_dest),
        .stage_wb_en       (stage_wb_en),
        .forwarding_enable (forwarding_enable),
        .issue_valid       (issue_valid),
        .issue_dest        (issue_dest),
        .issue_wb_en       (issue_wb_en),
        .issue_lat         (issue_lat),
        .flush             (flush),
        .fwd_sel           (fwd_sel),
        .stall             (stall),
        .issue_fire        (issue_fire),
        .stall_cnt         (stall_cnt)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past the next rising edge; inputs are then driven and
    // outputs sampled well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [REG_AW-1:0] addr, input logic used);
        src_addr[i*REG_AW +: REG_AW] = addr;
        src_used[i] = used;
    endtask

    task automatic set_stage(input int k, input logic [REG_AW-1:0] dest, input logic wb);
        stage_dest[k*REG_AW +: REG_AW] = dest;
        stage_wb_en[k] = wb;
    endtask

    task automatic clear_inputs();
        src_addr          = '0;
        src_used          = '0;
        stage_dest        = '0;
        stage_wb_en       = '0;
        forwarding_enable = 1'b1;
        issue_valid       = 1'b0;
        issue_dest        = '0;
        issue_wb_en       = 1'b0;
        issue_lat         = '0;
        flush             = 1'b0;
    endtask

    task automatic issue(input logic [REG_AW-1:0] dest, input logic wb, input logic [LAT_W-1:0] lat);
        issue_valid = 1'b1;
        issue_dest  = dest;
        issue_wb_en = wb;
        issue_lat   = lat;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        rst_n = 1'b0;

        // Reset state
        #2;
        check("rst_fwd_sel", 32'(fwd_sel), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Priority: both stages hold r8, youngest wins
        set_src(0, 5'd8, 1'b1);
        set_stage(0, 5'd8, 1'b1);
        set_stage(1, 5'd8, 1'b1);
        #1;
        check("prio_both", 32'(fwd_sel), 32'h01);
        check("prio_stall", 32'(stall), 32'h0);
        stage_wb_en[0] = 1'b0;
        #1;
        check("prio_old_only", 32'(fwd_sel), 32'h02);

        // r0 never forwards: stage 0 writes r0, operand 1 reads r0
        set_stage(0, 5'd0, 1'b1);
        set_src(1, 5'd0, 1'b1);
        #1;
        check("r0_no_fwd", 32'(fwd_sel), 32'h02);

        // Unused operand 2 reads r9 held in stage 0: no select, no stall
        set_stage(0, 5'd9, 1'b1);
        set_src(2, 5'd9, 1'b0);
        issue(5'd0, 1'b0, 3'd0);
        #1;
        check("unused_sel", 32'(fwd_sel), 32'h02);
        check("unused_stall", 32'(stall), 32'h0);
        check("unused_fire", 32'(issue_fire), 32'h1);
        tick();
        clear_inputs();

        // Load-use: r10 with latency 2 issues at t
        issue(5'd10, 1'b1, 3'd2);
        #1;
        check("lu_t_fire", 32'(issue_fire), 32'h1);
        tick();
        clear_inputs();
        issue(5'd0, 1'b0, 3'd0);
        set_src(0, 5'd10, 1'b1);
        #1;
        check("lu_t1_stall", 32'(stall), 32'h1);
        check("lu_t1_fire", 32'(issue_fire), 32'h0);
        tick();
        check("lu_t2_stall", 32'(stall), 32'h1);
        tick();
        check("lu_t3_stall", 32'(stall), 32'h0);
        check("lu_t3_fire", 32'(issue_fire), 32'h1);
        check("lu_stall_cnt", 32'(stall_cnt), 32'h2);
        tick();
        clear_inputs();

        // WAW: r12 loaded with 3, then a second writer of r12 stalls
        issue(5'd12, 1'b1, 3'd3);
        tick();
        issue(5'd12, 1'b1, 3'd1);
        #1;
        check("waw_stall", 32'(stall), 32'h1);
        tick();
        check("waw_stall_cnt", 32'(stall_cnt), 32'h3);

        // Flush together with an issue of r5 (lat 4): issue is dropped
        issue(5'd5, 1'b1, 3'd4);
        flush = 1'b1;
        #1;
        check("flush_cycle_stall", 32'(stall), 32'h0);
        tick();
        clear_inputs();
        issue(5'd0, 1'b0, 3'd0);
        set_src(0, 5'd12, 1'b1);
        set_src(1, 5'd5, 1'b1);
        #1;
        check("flush_cleared_stall", 32'(stall), 32'h0);
        tick();
        check("flush_keeps_cnt", 32'(stall_cnt), 32'h3);
        clear_inputs();

        // Interlock mode: stage 1 holds r7, operand reads r7
        forwarding_enable = 1'b0;
        set_stage(1, 5'd7, 1'b1);
        set_src(0, 5'd7, 1'b1);
        issue(5'd0, 1'b0, 3'd0);
        #1;
        check("il_fwd_sel", 32'(fwd_sel), 32'h0);
        check("il_stall", 32'(stall), 32'h1);
        check("il_fire", 32'(issue_fire), 32'h0);
        tick();
        check("il_stall_cnt", 32'(stall_cnt), 32'h4);
        issue_valid = 1'b0;
        #1;
        check("il_no_valid_stall", 32'(stall), 32'h0);
        tick();
        check("il_cnt_hold", 32'(stall_cnt), 32'h4);

        // Saturation: 15 more stalled cycles from 4 must stop at 15
        issue_valid = 1'b1;
        for (int n = 0; n < 15; n++) begin
            tick();
        end
        check("sat_15", 32'(stall_cnt), 32'hf);
        tick();
        tick();
        check("sat_hold", 32'(stall_cnt), 32'hf);
        clear_inputs();

        // Asynchronous reset mid-operation: r20 busy for 7 cycles
        issue(5'd20, 1'b1, 3'd7);
        tick();
        clear_inputs();
        issue(5'd0, 1'b0, 3'd0);
        set_src(0, 5'd20, 1'b1);
        #1;
        check("pre_rst_busy", 32'(stall), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_cnt", 32'(stall_cnt), 32'h0);
        rst_n = 1'b1;
        #1;
        check("async_rst_sb", 32'(stall), 32'h0);
        check("async_rst_fire", 32'(issue_fire), 32'h1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
